// File: rtl/sw_loop_pkg.sv
// Shared location encoding and helpers for the nested software-loop benchmark.
package sw_loop_pkg;

  typedef enum logic [2:0] {
    L0 = 3'd0, L1 = 3'd1, L2 = 3'd2, L3 = 3'd3,
    L4 = 3'd4, L5 = 3'd5, L6 = 3'd6, L7 = 3'd7
  } loc_e;

  localparam int unsigned NUM_LOC = 8;

  // Width of the outer counter: clog2(n), never below one bit.
  function automatic int yw_of(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic logic [7:0] loc_onehot(input loc_e l);
    return 8'd1 << l;
  endfunction

  function automatic logic is_onehot(input logic [7:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) c++;
    end
    return (c == 1);
  endfunction

  // Lowest set bit wins when the vector is not one-hot.
  function automatic loc_e first_loc(input logic [7:0] v);
    loc_e r;
    r = L0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = loc_e'(i[2:0]);
    end
    return r;
  endfunction

  function automatic loc_e next_loc(input loc_e l, input logic lt_prop,
                                    input logic lt_cond, input logic y_last);
    loc_e n;
    case (l)
      L0:      n = L1;
      L1:      n = lt_prop ? L2 : L6;
      L2:      n = L3;
      L3:      n = lt_cond ? L1 : L4;
      L4:      n = lt_prop ? L5 : L6;
      L5:      n = y_last ? L7 : L1;
      L6:      n = L6;
      L7:      n = L7;
      default: n = L0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sw_loop_pc.sv
// Program-counter register and next-location logic. SW_LOOP_ONEHOT_GUARD_EN selects
// eight independent flops with a registered one-hot guard instead of a binary PC.
module sw_loop_pc
  import sw_loop_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_i,
  input  logic       lt_prop_i,
  input  logic       lt_cond_i,
  input  logic       y_last_i,
  output logic [7:0] pc_o,
  output logic       adv_o,
  output logic       guard_ok_o
);

`ifdef SW_LOOP_ONEHOT_GUARD_EN
  logic [7:0] pc_q, pc_d;
  logic       onehot_q;

  // A corrupted PC still decodes to some location; the guard stops it one edge later.
  always_comb begin
    pc_d = loc_onehot(next_loc(first_loc(pc_q), lt_prop_i, lt_cond_i, y_last_i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= loc_onehot(L0);
      onehot_q <= 1'b1;
    end else begin
      onehot_q <= is_onehot(pc_q);
      if (adv_o) pc_q <= pc_d;
      else       pc_q <= pc_q;
    end
  end

  assign adv_o      = step_i && onehot_q;
  assign guard_ok_o = onehot_q;
  assign pc_o       = pc_q;
`else
  loc_e loc_q, loc_d;

  always_comb begin
    loc_d = next_loc(loc_q, lt_prop_i, lt_cond_i, y_last_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         loc_q <= L0;
    else if (adv_o)  loc_q <= loc_d;
    else             loc_q <= loc_q;
  end

  assign adv_o      = step_i;
  assign guard_ok_o = 1'b1;
  assign pc_o       = loc_onehot(loc_q);
`endif

endmodule

// File: rtl/sw_loop_nested.sv
// Nested counting loop (inner x, outer y) as a PC state machine; prop = !err.
// Optional build macro: SW_LOOP_ONEHOT_GUARD_EN (one-hot PC with guard_ok check).
module sw_loop_nested
  import sw_loop_pkg::*;
#(
  parameter int W       = 6,
  parameter int K_INIT  = 1,
  parameter int K_INC   = 3,
  parameter int K_COND  = 17,
  parameter int K_PROP  = 20,
  parameter int N_OUTER = 2,
  localparam int YW     = yw_of(N_OUTER)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic [7:0]    pc,
  output logic [W-1:0]  x,
  output logic [YW-1:0] y,
  output logic          done,
  output logic          err,
  output logic          prop,
  output logic          guard_ok
);

  localparam logic [W-1:0]  KINIT_W = W'(K_INIT);
  localparam logic [W-1:0]  KINC_W  = W'(K_INC);
  localparam logic [W-1:0]  KCOND_W = W'(K_COND);
  localparam logic [W-1:0]  KPROP_W = W'(K_PROP);
  localparam logic [YW-1:0] Y_LAST  = YW'(N_OUTER - 1);

  logic [W-1:0]  x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    pc_s;
  logic          adv, lt_prop, lt_cond, y_last;

  assign lt_prop = (x_q < KPROP_W);
  assign lt_cond = (x_q < KCOND_W);
  assign y_last  = (y_q == Y_LAST);

  sw_loop_pc u_pc (
    .clk        (clk),
    .rst        (rst),
    .step_i     (step),
    .lt_prop_i  (lt_prop),
    .lt_cond_i  (lt_cond),
    .y_last_i   (y_last),
    .pc_o       (pc_s),
    .adv_o      (adv),
    .guard_ok_o (guard_ok)
  );

  // Only L0, L2 and L5 write data; the x increment wraps modulo 2^W.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv) begin
      if (pc_s[L0]) begin
        x_d = KINIT_W;
        y_d = {YW{1'b0}};
      end else if (pc_s[L2]) begin
        x_d = x_q + KINC_W;
      end else if (pc_s[L5] && !y_last) begin
        x_d = KINIT_W;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q;
      end
    end else begin
      x_d = x_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= KINIT_W;
      y_q <= {YW{1'b0}};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign pc   = pc_s;
  assign x    = x_q;
  assign y    = y_q;
  assign done = pc_s[L7];
  assign err  = pc_s[L6];
  assign prop = !pc_s[L6];

endmodule

// File: tb/tb_sw_loop_nested.sv
// Directed bench for sw_loop_nested: default run, error bound, step gating, async reset, wrap.
module tb_sw_loop_nested;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step = 1'b0;
  int checks = 0;
  int errors = 0;

  // Default configuration
  logic [7:0] pc_a;  logic [5:0] x_a;  logic y_a;
  logic done_a, err_a, prop_a, gok_a;
  // K_PROP = 19
  logic [7:0] pc_b;  logic [5:0] x_b;  logic y_b;
  logic done_b, err_b, prop_b, gok_b;
  // 4-bit wrap configuration
  logic [7:0] pc_c;  logic [3:0] x_c;  logic y_c;
  logic done_c, err_c, prop_c, gok_c;

  always #5 clk = ~clk;

  sw_loop_nested dut (
    .clk(clk), .rst(rst), .step(step), .pc(pc_a), .x(x_a), .y(y_a),
    .done(done_a), .err(err_a), .prop(prop_a), .guard_ok(gok_a)
  );

  sw_loop_nested #(.K_PROP(19)) dut_kp (
    .clk(clk), .rst(rst), .step(step), .pc(pc_b), .x(x_b), .y(y_b),
    .done(done_b), .err(err_b), .prop(prop_b), .guard_ok(gok_b)
  );

  sw_loop_nested #(.W(4), .K_INIT(1), .K_INC(5), .K_COND(15), .K_PROP(15), .N_OUTER(1)) dut_wr (
    .clk(clk), .rst(rst), .step(step), .pc(pc_c), .x(x_c), .y(y_c),
    .done(done_c), .err(err_c), .prop(prop_c), .guard_ok(gok_c)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    step = 1'b0;
    #2;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (pc_a !== 8'h01 || x_a !== 6'd1 || y_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h x=%0d y=%0d, want pc=01 x=1 y=0", pc_a, x_a, y_a);
    end
    checks++;
    if (done_a !== 1'b0 || err_a !== 1'b0 || prop_a !== 1'b1 || gok_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: done=%b err=%b prop=%b guard_ok=%b, want 0 0 1 1",
               done_a, err_a, prop_a, gok_a);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default_run();
    do_reset();
    step = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick();
      checks++;
      if (err_a !== 1'b0 || gok_a !== 1'b1) begin
        errors++;
        $display("FAIL run_err_guard@%0d: err=%b guard_ok=%b, want 0 1", e, err_a, gok_a);
      end
      if (e == 1 || e == 19 || e == 20) begin
        checks++;
        if (pc_a !== (e == 1 ? 8'h02 : (e == 19 ? 8'h10 : 8'h20)) || y_a !== 1'b0) begin
          errors++;
          $display("FAIL run_pc@%0d: pc=%h y=%0d", e, pc_a, y_a);
        end
      end
      if (e == 21) begin
        checks++;
        if (pc_a !== 8'h02 || y_a !== 1'b1 || x_a !== 6'd1) begin
          errors++;
          $display("FAIL run_outer2: pc=%h x=%0d y=%0d, want pc=02 x=1 y=1", pc_a, x_a, y_a);
        end
      end
      if (e == 40) begin
        checks++;
        if (pc_a !== 8'h20 || done_a !== 1'b0) begin
          errors++;
          $display("FAIL run_l5_last: pc=%h done=%b, want pc=20 done=0", pc_a, done_a);
        end
      end
      if (e >= 41) begin
        checks++;
        if (done_a !== 1'b1 || pc_a !== 8'h80 || x_a !== 6'd19 || y_a !== 1'b1) begin
          errors++;
          $display("FAIL run_done@%0d: done=%b pc=%h x=%0d y=%0d, want 1 80 19 1",
                   e, done_a, pc_a, x_a, y_a);
        end
      end
    end
  endtask

  task automatic test_err_bound();
    do_reset();
    step = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (e == 19) begin
        checks++;
        if (pc_b !== 8'h10 || x_b !== 6'd19 || err_b !== 1'b0) begin
          errors++;
          $display("FAIL kprop_l4: pc=%h x=%0d err=%b, want pc=10 x=19 err=0", pc_b, x_b, err_b);
        end
      end
      if (e >= 20) begin
        checks++;
        if (err_b !== 1'b1 || prop_b !== 1'b0 || x_b !== 6'd19 || y_b !== 1'b0 || pc_b !== 8'h40) begin
          errors++;
          $display("FAIL kprop_err@%0d: err=%b prop=%b pc=%h x=%0d y=%0d", e, err_b, prop_b, pc_b, x_b, y_b);
        end
      end
    end
  endtask

  task automatic test_step_gating();
    int n;
    n = 0;
    do_reset();
    for (int i = 0; i < 84; i++) begin
      step = (i % 2 == 0);
      tick();
      if (step) n++;
      if (n == 19 || n == 20) begin
        checks++;
        if (pc_a !== (n == 19 ? 8'h10 : 8'h20) || y_a !== 1'b0 || x_a !== 6'd19) begin
          errors++;
          $display("FAIL gate_pc@%0d/%0d: pc=%h x=%0d y=%0d", i, n, pc_a, x_a, y_a);
        end
      end
      if (n == 21) begin
        checks++;
        if (pc_a !== 8'h02 || y_a !== 1'b1 || x_a !== 6'd1) begin
          errors++;
          $display("FAIL gate_outer2@%0d: pc=%h x=%0d y=%0d, want 02 1 1", i, pc_a, x_a, y_a);
        end
      end
      if (n >= 1 && n < 41) begin
        checks++;
        if (done_a !== 1'b0) begin
          errors++;
          $display("FAIL gate_early_done@%0d: done=%b, want 0", n, done_a);
        end
      end
      if (n >= 41) begin
        checks++;
        if (done_a !== 1'b1 || x_a !== 6'd19) begin
          errors++;
          $display("FAIL gate_done@%0d: done=%b x=%0d, want 1 19", n, done_a, x_a);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step = 1'b1;
    repeat (9) tick();
    checks++;
    if (pc_a !== 8'h08 || x_a !== 6'd10) begin
      errors++;
      $display("FAIL areset_pre: pc=%h x=%0d, want 08 10", pc_a, x_a);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pc_a !== 8'h01 || x_a !== 6'd1 || y_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: pc=%h x=%0d y=%0d, want 01 1 0", pc_a, x_a, y_a);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      tick();
      if (e >= 40) begin
        checks++;
        if (done_a !== (e == 41)) begin
          errors++;
          $display("FAIL areset_rerun@%0d: done=%b, want %0d", e, done_a, (e == 41));
        end
      end
    end
    // A sticky state must not survive reset.
    rst = 1'b1;
    #1;
    checks++;
    if (done_a !== 1'b0 || pc_a !== 8'h01) begin
      errors++;
      $display("FAIL areset_sticky: done=%b pc=%h, want 0 01", done_a, pc_a);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_x [6];
    int k;
    exp_x = '{4'd6, 4'd11, 4'd0, 4'd5, 4'd10, 4'd15};
    k = 0;
    do_reset();
    step = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (e % 3 == 0 && e <= 18) begin
        checks++;
        if (pc_c !== 8'h08 || x_c !== exp_x[k]) begin
          errors++;
          $display("FAIL wrap_x%0d: pc=%h x=%0d, want 08 %0d", k, pc_c, x_c, exp_x[k]);
        end
        k++;
      end
      if (e == 19) begin
        checks++;
        if (pc_c !== 8'h10 || err_c !== 1'b0) begin
          errors++;
          $display("FAIL wrap_l4: pc=%h err=%b, want 10 0", pc_c, err_c);
        end
      end
      if (e >= 20) begin
        checks++;
        if (err_c !== 1'b1 || prop_c !== 1'b0 || x_c !== 4'd15) begin
          errors++;
          $display("FAIL wrap_err@%0d: err=%b prop=%b x=%0d, want 1 0 15", e, err_c, prop_c, x_c);
        end
      end
    end
  endtask

  task automatic test_guard();
    do_reset();
    step = 1'b1;
    repeat (2) tick();
`ifdef SW_LOOP_ONEHOT_GUARD_EN
    force dut.u_pc.pc_q = 8'b0000_0110;
    tick();
    release dut.u_pc.pc_q;
    checks++;
    if (gok_a !== 1'b0) begin
      errors++;
      $display("FAIL guard_drop: guard_ok=%b, want 0", gok_a);
    end
    repeat (3) tick();
    checks++;
    if (gok_a !== 1'b0 || pc_a !== 8'b0000_0110) begin
      errors++;
      $display("FAIL guard_frozen: guard_ok=%b pc=%h, want 0 06", gok_a, pc_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gok_a !== 1'b1 || pc_a !== 8'h01) begin
      errors++;
      $display("FAIL guard_recover: guard_ok=%b pc=%h, want 1 01", gok_a, pc_a);
    end
    @(negedge clk);
    rst = 1'b0;
`else
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (gok_a !== 1'b1 || gok_c !== 1'b1) begin
        errors++;
        $display("FAIL guard_tied@%0d: guard_ok=%b/%b, want 1", e, gok_a, gok_c);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_err_bound();
    test_step_gating();
    test_async_reset();
    test_wrap();
    test_guard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
